cpu_step_ctrl: RTL and testbench

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 21 ++
 rtl/interval_timer.sv | 28 ++
 rtl/cpu_step_ctrl.sv | 157 +++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and default widths for the CPU step/run controller.
package cpu_ctrl_pkg;

  localparam int DIV_W_DEF = 10;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    MODE_HALT   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_BURST  = 2'b10,
    MODE_RUN    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_REL = 2'd1,
    ST_BURST    = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

endpackage

// File: rtl/interval_timer.sv
// Reloadable down-counter: load sets the count, otherwise it counts down and
// parks at zero; zero flags the cycle on which the next pulse may issue.
module interval_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_step_ctrl.sv
// Step/burst/run clock-enable controller for a teaching CPU: turns a button
// level and a mode selector into one-cycle PC advance pulses.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_req,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [DIV_W-1:0] div,
  output logic             pc_en,
  output logic [CNT_W-1:0] single_count,
  output logic             busy,
  output logic [1:0]       state
);

  state_e           state_q;
  state_e           state_d;
  mode_e            mode_in;
  logic             step_q;
  logic             rise;
  logic [CNT_W-1:0] remaining;
  logic [DIV_W-1:0] gap_l;

  logic             fire;
  logic             latch_gap;
  logic             latch_burst;
  logic             timer_load;
  logic [DIV_W-1:0] timer_val;
  logic             timer_zero;

  assign mode_in = mode_e'(mode);
  assign rise    = step_req & ~step_q;
  assign state   = state_q;

  interval_timer #(
    .WIDTH(DIV_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mode_in == MODE_RUN) begin
          state_d = ST_RUN;
        end else if (rise && mode_in == MODE_SINGLE) begin
          state_d = ST_WAIT_REL;
        end else if (rise && mode_in == MODE_BURST) begin
          state_d = (burst_len == '0) ? ST_WAIT_REL : ST_BURST;
        end
      end
      ST_WAIT_REL: begin
        if (!step_q) state_d = ST_IDLE;
      end
      ST_BURST: begin
        // Only HALT may cut a burst short; other mode changes wait for its end.
        if (mode_in == MODE_HALT) begin
          state_d = ST_IDLE;
        end else if (remaining == '0) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_RUN: begin
        if (mode_in != MODE_RUN) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry into BURST/RUN loads the timer with zero so the first pulse
  // follows entry by one cycle; each pulse reloads with the latched gap.
  always_comb begin
    fire        = 1'b0;
    latch_gap   = 1'b0;
    latch_burst = 1'b0;
    timer_load  = 1'b0;
    timer_val   = gap_l;
    unique case (state_q)
      ST_IDLE: begin
        if (mode_in == MODE_RUN) begin
          latch_gap  = 1'b1;
          timer_load = 1'b1;
          timer_val  = '0;
        end else if (rise && mode_in == MODE_SINGLE) begin
          fire = 1'b1;
        end else if (rise && mode_in == MODE_BURST) begin
          latch_gap   = 1'b1;
          latch_burst = 1'b1;
          timer_load  = 1'b1;
          timer_val   = '0;
        end
      end
      ST_BURST: begin
        if (mode_in != MODE_HALT && remaining != '0 && timer_zero) begin
          fire       = 1'b1;
          timer_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (mode_in == MODE_RUN && timer_zero) begin
          fire       = 1'b1;
          timer_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // step_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q       <= 1'b1;
      remaining    <= '0;
      gap_l        <= '0;
      pc_en        <= 1'b0;
      single_count <= '0;
      busy         <= 1'b0;
    end else begin
      step_q <= step_req;
      pc_en  <= fire;
      busy   <= (state_d == ST_BURST) || (state_d == ST_RUN);
      if (fire) single_count <= single_count + CNT_W'(1);
      if (latch_gap) gap_l <= div;
      if (latch_burst) begin
        remaining <= burst_len;
      end else if (fire && state_q == ST_BURST) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  a_busy_tracks_state: assert property (@(posedge clk) disable iff (rst)
    busy == (state_q == ST_BURST || state_q == ST_RUN));

  a_no_pulse_in_idle: assert property (@(posedge clk) disable iff (rst)
    pc_en |-> state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: expected pulse cycles are queued as
// stimulus is driven and matched against pc_en as it appears.
module tb_cpu_step_ctrl;

  localparam int DIV_W = 10;
  localparam int CNT_W = 6;

  logic             clk;
  logic             rst;
  logic             step_req;
  logic [1:0]       mode;
  logic [CNT_W-1:0] burst_len;
  logic [DIV_W-1:0] div;
  logic             pc_en;
  logic [CNT_W-1:0] single_count;
  logic             busy;
  logic [1:0]       state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q[$];

  cpu_step_ctrl #(
    .DIV_W(DIV_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .step_req     (step_req),
    .mode         (mode),
    .burst_len    (burst_len),
    .div          (div),
    .pc_en        (pc_en),
    .single_count (single_count),
    .busy         (busy),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every observed pulse must match the oldest queued expected cycle.
  always @(negedge clk) begin
    if (!rst && pc_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pc_en", pc_en, 0);
      end else begin
        check("pulse_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    step_req  = 1'b0;
    mode      = 2'b00;
    burst_len = '0;
    div       = '0;
    run(2);
    rst = 1'b0;
    run(3);
  endtask

  task automatic check_drained(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int c;
    rst       = 1'b1;
    step_req  = 1'b0;
    mode      = 2'b00;
    burst_len = '0;
    div       = '0;
    run(2);
    check("rst_state", state, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_count", single_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    run(3);

    // SINGLE: button held 20 cycles gives one pulse, one cycle after the edge.
    c = cyc;
    mode     = 2'b01;
    step_req = 1'b1;
    exp_q.push_back(c + 1);
    tick();
    check("single_wait_rel", state, 1);
    run(19);
    step_req = 1'b0;
    run(3);
    check("single_idle", state, 0);
    check("single_count", single_count, 1);
    check_drained("single_missing");

    // BURST: 5 pulses spaced div+1 = 4 cycles apart.
    do_reset();
    c = cyc;
    mode      = 2'b10;
    burst_len = 6'd5;
    div       = 10'd3;
    step_req  = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(c + 2 + 4 * i);
    run(2);
    step_req = 1'b0;
    div      = 10'd0;
    tick();
    check("burst_busy", busy, 1);
    check("burst_state", state, 2);
    run(16);
    check("burst_done_busy", busy, 0);
    check("burst_done_state", state, 1);
    tick();
    check("burst_idle", state, 0);
    check("burst_count", single_count, 5);
    check_drained("burst_missing");

    // RUN with div=0: ten back-to-back pulses, none after leaving RUN.
    do_reset();
    c = cyc;
    mode = 2'b11;
    div  = 10'd0;
    for (int i = 0; i < 10; i++) exp_q.push_back(c + 2 + i);
    run(5);
    div = 10'd5;
    run(6);
    mode = 2'b01;
    tick();
    check("run_exit_state", state, 0);
    check("run_exit_busy", busy, 0);
    run(4);
    check("run_count", single_count, 10);
    check_drained("run_missing");

    // BURST abort: HALT on a due-pulse cycle after the third pulse.
    do_reset();
    c = cyc;
    mode      = 2'b10;
    burst_len = 6'd40;
    div       = 10'd1;
    step_req  = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(c + 2 + 2 * i);
    run(2);
    step_req = 1'b0;
    tick();
    mode = 2'b01;
    run(4);
    mode = 2'b00;
    tick();
    check("abort_state", state, 0);
    run(6);
    check("abort_count", single_count, 3);
    check_drained("abort_missing");

    // Wrap: 65 single steps leave the 6-bit count at 1.
    do_reset();
    mode = 2'b01;
    for (int i = 0; i < 65; i++) begin
      step_req = 1'b1;
      exp_q.push_back(cyc + 1);
      run(2);
      step_req = 1'b0;
      run(3);
    end
    check("wrap_count", single_count, 1);
    check_drained("wrap_missing");

    // BURST with length 0: straight to WAIT_REL, no pulse.
    do_reset();
    mode      = 2'b10;
    burst_len = 6'd0;
    div       = 10'd2;
    step_req  = 1'b1;
    tick();
    check("zero_len_state", state, 1);
    check("zero_len_busy", busy, 0);
    tick();
    step_req = 1'b0;
    run(3);
    check("zero_len_idle", state, 0);
    check("zero_len_count", single_count, 0);
    check_drained("zero_len_missing");

    // Asynchronous reset mid-RUN, button held through release.
    do_reset();
    c = cyc;
    mode = 2'b11;
    div  = 10'd0;
    for (int i = 0; i < 3; i++) exp_q.push_back(c + 2 + i);
    run(5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc_en", pc_en, 0);
    check("arst_busy", busy, 0);
    check("arst_state", state, 0);
    check("arst_count", single_count, 0);
    check_drained("arst_missing");
    mode     = 2'b01;
    step_req = 1'b1;
    run(2);
    rst = 1'b0;
    run(6);
    check("arst_held_count", single_count, 0);
    check("arst_held_state", state, 0);
    step_req = 1'b0;
    run(2);
    check_drained("arst_spurious");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
